uart_tx_sched: RTL

- Round-robin scheduler that shares one uart_tx transmitter between NREQ byte requesters.
- Each requester raises a request with a byte. The scheduler grants one requester, launches the byte with a single-cycle send pulse, waits for the transmitter's done pulse, then acknowledges that requester.
- Sits between the user-side byte producers (status reporter, debug dumper, etc.) and the uart_tx instance.
- Includes a watchdog so a stalled transmitter cannot lock up the scheduler.

---
 rtl/uart_tx_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_tx between NREQ byte requesters
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req, req_data   per-requester request level and byte (byte i in bits [8i+7:8i])
//   ack, err        one-cycle completion / watchdog-abort pulse to the owning requester
//   grant           one-hot current owner, 0 when idle
//   tx_send/tx_data launch pulse and byte towards uart_tx
//   tx_busy/tx_done status back from uart_tx
//
// Optional feature: define UART_TX_SCHED_TAG_EN to precede every payload with
// a tag byte {5'b10100, idx[2:0]}.
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   err,
    output logic [NREQ-1:0]   grant,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_done
);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        LAUNCH        = 3'd1,
        WAIT_BUSY     = 3'd2,
        WAIT_DONE     = 3'd3,
        TAG_LAUNCH    = 3'd4,
        TAG_WAIT_BUSY = 3'd5,
        TAG_WAIT_DONE = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        idx_q, idx_d;
    logic [9:0]        wd_q, wd_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              tx_send_q, tx_send_d;
    logic [7:0]        tx_data_q, tx_data_d;
`ifdef UART_TX_SCHED_TAG_EN
    logic [7:0]        payload_q, payload_d;
`endif

    // Rotating search: first set request bit at or above ptr, wrapping.
    logic              found;
    logic [2:0]        sel_idx;
    logic [7:0]        sel_byte;
    logic [NREQ-1:0]   sel_onehot;
    logic [3:0]        cand;

    always_comb begin
        found      = 1'b0;
        sel_idx    = 3'd0;
        sel_byte   = 8'h00;
        sel_onehot = '0;
        cand       = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!found && cand == 4'(i) && req[i]) begin
                    found   = 1'b1;
                    sel_idx = 3'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == 3'(i)) begin
                sel_byte = req_data[8*i +: 8];
            end
            sel_onehot[i] = found && (sel_idx == 3'(i));
        end
    end

    logic [2:0] ptr_next;
    logic       wd_expired;

    assign ptr_next   = (idx_q == 3'(NREQ-1)) ? 3'd0 : idx_q + 3'd1;
    assign wd_expired = (wd_q == 10'(TIMEOUT-1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        wd_d      = wd_q;
        grant_d   = grant_q;
        ack_d     = '0;
        err_d     = '0;
        tx_send_d = 1'b0;
        tx_data_d = tx_data_q;
`ifdef UART_TX_SCHED_TAG_EN
        payload_d = payload_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d   = sel_onehot;
                    idx_d     = sel_idx;
                    tx_send_d = 1'b1;
`ifdef UART_TX_SCHED_TAG_EN
                    tx_data_d = {5'b10100, sel_idx};
                    payload_d = sel_byte;
                    state_d   = TAG_LAUNCH;
`else
                    tx_data_d = sel_byte;
                    state_d   = LAUNCH;
`endif
                end
            end
            LAUNCH: begin
                wd_d    = 10'd0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
                // A done that beats busy is still a completed frame.
                if (tx_done) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end else if (wd_expired) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 10'd1;
                    if (state_q == WAIT_BUSY && tx_busy) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
`ifdef UART_TX_SCHED_TAG_EN
            TAG_LAUNCH: begin
                wd_d    = 10'd0;
                state_d = TAG_WAIT_BUSY;
            end
            TAG_WAIT_BUSY, TAG_WAIT_DONE: begin
                if (tx_done) begin
                    tx_send_d = 1'b1;
                    tx_data_d = payload_q;
                    state_d   = LAUNCH;
                end else if (wd_expired) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 10'd1;
                    if (state_q == TAG_WAIT_BUSY && tx_busy) begin
                        state_d = TAG_WAIT_DONE;
                    end
                end
            end
`endif
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            wd_q      <= 10'd0;
            grant_q   <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            tx_send_q <= 1'b0;
            tx_data_q <= 8'h00;
`ifdef UART_TX_SCHED_TAG_EN
            payload_q <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            wd_q      <= wd_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            tx_send_q <= tx_send_d;
            tx_data_q <= tx_data_d;
`ifdef UART_TX_SCHED_TAG_EN
            payload_q <= payload_d;
`endif
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign grant   = grant_q;
    assign tx_send = tx_send_q;
    assign tx_data = tx_data_q;

endmodule
